// File: rtl/multi_sync_gen_if.sv
// Control/status bundle for the multi-channel sync generator.
// The generator consumes the slave view; a controller or bench drives the master view.
interface multi_sync_gen_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PW_W   = 8
);
    logic                    enable;
    logic                    sync_mode;
    logic [CNT_W-1:0]        cnt_max;
    logic [PW_W-1:0]         pulse_width;
    logic [NUM_CH*CNT_W-1:0] phase_offset;
    logic [NUM_CH-1:0]       ch_enable;
    logic                    network_sync;
    logic                    irq_ack;
    logic [CNT_W-1:0]        period_count;
    logic                    master_sync;
    logic [NUM_CH-1:0]       ch_sync;
    logic                    interrupt_sig;
    logic                    irq_overrun;
    logic                    sync_lost;

    modport master (
        output enable, sync_mode, cnt_max, pulse_width, phase_offset,
               ch_enable, network_sync, irq_ack,
        input  period_count, master_sync, ch_sync, interrupt_sig,
               irq_overrun, sync_lost
    );

    modport slave (
        input  enable, sync_mode, cnt_max, pulse_width, phase_offset,
               ch_enable, network_sync, irq_ack,
        output period_count, master_sync, ch_sync, interrupt_sig,
               irq_overrun, sync_lost
    );
endinterface

// File: rtl/multi_sync_gen.sv
// Period counter with a master sync pulse and NUM_CH phase-offset channel pulses.
// Optional lock to an asynchronous network sync, sticky period interrupt,
// missed-ack overrun flag and holdover (sync lost) detection.
module multi_sync_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PW_W   = 8
) (
    input  logic              clock_sync,
    input  logic              reset,
    multi_sync_gen_if.slave   bus
);
    // One extra bit so period/width/offset arithmetic never overflows.
    localparam int XW = ((CNT_W > PW_W) ? CNT_W : PW_W) + 1;

    logic                    running, run_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [CNT_W-1:0]        sh_max, sh_max_n;
    logic [PW_W-1:0]         sh_pw, sh_pw_n;
    logic [NUM_CH*CNT_W-1:0] sh_off, sh_off_n;
    logic                    ns_meta, ns_sync, ns_prev;
    logic                    net_edge, wrap, load, nat_wrap, period_start;
    logic                    wrap_seen, lost_q;
    logic                    irq_q, ovr_q, ms_q, ms_n;
    logic [NUM_CH-1:0]       ch_q, ch_n;
    logic [XW-1:0]           per_c, per_n, wid_n, off_v, diff_v;

    // Effective period: never shorter than 2 clocks.
    function automatic logic [XW-1:0] eff_period(input logic [CNT_W-1:0] m);
        return (m < CNT_W'(2)) ? XW'(2) : XW'(m);
    endfunction

    // Effective pulse width: at least 1, at most one clock short of the period.
    function automatic logic [XW-1:0] eff_width(input logic [PW_W-1:0] pw,
                                                input logic [XW-1:0] p);
        logic [XW-1:0] w;
        w = XW'(pw);
        if (w == '0)
            return XW'(1);
        if (w > p - XW'(1))
            return p - XW'(1);
        return w;
    endfunction

    // Next-state: counter, shadow reload and the registered pulse outputs.
    // Outputs are computed from the next count and next shadows so the
    // registered pulses line up with the count they describe.
    always_comb begin
        net_edge     = ns_sync & ~ns_prev & bus.sync_mode & running;
        per_c        = eff_period(sh_max);
        wrap         = running & (XW'(cnt) >= per_c - XW'(1));
        period_start = running & (cnt == '0);
        nat_wrap     = running & bus.enable & wrap & ~net_edge;
        run_n        = bus.enable;
        cnt_n        = '0;
        if (running && bus.enable && !net_edge && !wrap)
            cnt_n = cnt + CNT_W'(1);
        // Shadows track inputs while stopped and latch at every period start.
        load     = !running || (run_n && (cnt_n == '0));
        sh_max_n = load ? bus.cnt_max      : sh_max;
        sh_pw_n  = load ? bus.pulse_width  : sh_pw;
        sh_off_n = load ? bus.phase_offset : sh_off;
        per_n    = eff_period(sh_max_n);
        wid_n    = eff_width(sh_pw_n, per_n);
        ms_n     = run_n && (XW'(cnt_n) < wid_n);
        ch_n     = '0;
        off_v    = '0;
        diff_v   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            off_v  = XW'(sh_off_n[i*CNT_W +: CNT_W]);
            // Distance behind the channel offset, modulo the period.
            diff_v = (XW'(cnt_n) >= off_v) ? XW'(cnt_n) - off_v
                                           : XW'(cnt_n) + per_n - off_v;
            ch_n[i] = run_n && bus.ch_enable[i] && (off_v < per_n) && (diff_v < wid_n);
        end
    end

    // Two-flop synchroniser plus one delay flop for rising-edge detection.
    always_ff @(posedge clock_sync or posedge reset) begin
        if (reset) begin
            ns_meta <= 1'b0;
            ns_sync <= 1'b0;
            ns_prev <= 1'b0;
        end else begin
            ns_meta <= bus.network_sync;
            ns_sync <= ns_meta;
            ns_prev <= ns_sync;
        end
    end

    // Run state, period counter, shadows and registered sync pulses.
    always_ff @(posedge clock_sync or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
            sh_max  <= '0;
            sh_pw   <= '0;
            sh_off  <= '0;
            ms_q    <= 1'b0;
            ch_q    <= '0;
        end else begin
            running <= run_n;
            cnt     <= cnt_n;
            sh_max  <= sh_max_n;
            sh_pw   <= sh_pw_n;
            sh_off  <= sh_off_n;
            ms_q    <= ms_n;
            ch_q    <= ch_n;
        end
    end

    // Sticky interrupt and overrun; a period start beats a same-cycle ack.
    always_ff @(posedge clock_sync or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            if (period_start)
                irq_q <= 1'b1;
            else if (bus.irq_ack)
                irq_q <= 1'b0;
            if (period_start && irq_q)
                ovr_q <= 1'b1;
            else if (bus.irq_ack)
                ovr_q <= 1'b0;
        end
    end

    // Holdover tracking: two natural wraps with no network edge flag loss.
    always_ff @(posedge clock_sync or posedge reset) begin
        if (reset) begin
            wrap_seen <= 1'b0;
            lost_q    <= 1'b0;
        end else if (!bus.sync_mode || !run_n) begin
            wrap_seen <= 1'b0;
            lost_q    <= 1'b0;
        end else if (net_edge) begin
            wrap_seen <= 1'b0;
            lost_q    <= 1'b0;
        end else if (nat_wrap) begin
            if (wrap_seen)
                lost_q <= 1'b1;
            wrap_seen <= 1'b1;
        end
    end

    assign bus.period_count  = cnt;
    assign bus.master_sync   = ms_q;
    assign bus.ch_sync       = ch_q;
    assign bus.interrupt_sig = irq_q;
    assign bus.irq_overrun   = ovr_q;
    // Forced low the moment the mode drops or the block stops.
    assign bus.sync_lost     = lost_q & bus.sync_mode & running;
endmodule

// File: tb/tb_multi_sync_gen.sv
// Scoreboard bench for multi_sync_gen: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multi_sync_gen;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int PW_W   = 8;
    localparam logic [5:0] ALL    = 6'h3F;
    localparam logic [5:0] NO_IRQ = 6'h27;

    typedef struct packed {
        logic [5:0]  mask;   // cnt, ms, ch, irq, ovr, lost
        logic [15:0] cnt;
        logic        ms;
        logic [3:0]  ch;
        logic        irq;
        logic        ovr;
        logic        lost;
        logic [15:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_sync_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PW_W(PW_W)) bus();
    multi_sync_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PW_W(PW_W)) dut (
        .clock_sync (clk),
        .reset      (rst),
        .bus        (bus.slave)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    logic [3:0] tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int tag, input logic [5:0] mask, input int cnt,
                        input int ms, input int ch, input int irq, input int ovr,
                        input int lost);
        exp_t e;
        e.mask = mask;
        e.cnt  = 16'(cnt);
        e.ms   = ms[0];
        e.ch   = ch[3:0];
        e.irq  = irq[0];
        e.ovr  = ovr[0];
        e.lost = lost[0];
        e.tag  = 16'(tag);
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input int tag, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s tag=%0d got=%0d want=%0d", nm, tag, act, want);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.mask[0]) chk("period_count",  int'(mon_e.tag), int'(bus.period_count),  int'(mon_e.cnt));
            if (mon_e.mask[1]) chk("master_sync",   int'(mon_e.tag), int'(bus.master_sync),   int'(mon_e.ms));
            if (mon_e.mask[2]) chk("ch_sync",       int'(mon_e.tag), int'(bus.ch_sync),       int'(mon_e.ch));
            if (mon_e.mask[3]) chk("interrupt_sig", int'(mon_e.tag), int'(bus.interrupt_sig), int'(mon_e.irq));
            if (mon_e.mask[4]) chk("irq_overrun",   int'(mon_e.tag), int'(bus.irq_overrun),   int'(mon_e.ovr));
            if (mon_e.mask[5]) chk("sync_lost",     int'(mon_e.tag), int'(bus.sync_lost),     int'(mon_e.lost));
        end
    end

    initial begin
        int c;
        // Hand table: P=10, W=3, offsets {ch3=9, ch2=8, ch1=4, ch0=0}.
        tbl[0] = 4'b1101; tbl[1] = 4'b1001; tbl[2] = 4'b0001; tbl[3] = 4'b0000;
        tbl[4] = 4'b0010; tbl[5] = 4'b0010; tbl[6] = 4'b0010; tbl[7] = 4'b0000;
        tbl[8] = 4'b0100; tbl[9] = 4'b1100;

        bus.enable       = 1'b0;
        bus.sync_mode    = 1'b0;
        bus.cnt_max      = 16'd10;
        bus.pulse_width  = 8'd3;
        bus.phase_offset = {16'd9, 16'd8, 16'd4, 16'd0};
        bus.ch_enable    = 4'hF;
        bus.network_sync = 1'b0;
        bus.irq_ack      = 1'b0;

        // Reset state, then a stopped cycle.
        tick();
        push(0, ALL, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        push(1, ALL, 0, 0, 0, 0, 0, 0);
        bus.enable = 1'b1;

        // Free run P=10 W=3, ack in every count-5 cycle.
        for (int k = 0; k <= 22; k++) begin
            tick();
            c = k % 10;
            push(100 + k, ALL, c, int'(c < 3), int'(tbl[c]), int'(c >= 1 && c <= 5), 0, 0);
            bus.irq_ack = (c == 5);
            if (k == 22) begin
                bus.enable  = 1'b0;
                bus.irq_ack = 1'b0;
            end
        end

        // Stopped: outputs low, sticky interrupt holds; ch1 offset moved out of range.
        tick();
        push(200, ALL, 0, 0, 0, 1, 0, 0);
        bus.phase_offset = {16'd9, 16'd8, 16'd12, 16'd0};
        tick();
        push(201, ALL, 0, 0, 0, 1, 0, 0);
        bus.enable = 1'b1;

        // Restart with interrupt still pending: overrun, ack at a period start.
        for (int k = 0; k <= 14; k++) begin
            tick();
            c = k % 10;
            push(300 + k, ALL, c, int'(c < 3), int'(tbl[c] & 4'b1101),
                 int'(k <= 12), int'(k >= 1 && k <= 12), 0);
            bus.irq_ack = (k == 10 || k == 12);
        end

        // cnt_max 10->20 at count 5: old period finishes first.
        for (int j = 0; j <= 9; j++) begin
            tick();
            if (j <= 4) begin
                c = j + 5;
                push(400 + j, ALL, c, 0, int'(tbl[c] & 4'b1101), 0, 0, 0);
            end else begin
                c = j - 5;
                push(400 + j, ALL, c, int'(c < 3), (c < 3) ? 1 : 0, int'(j >= 6), 0, 0);
            end
            bus.irq_ack = 1'b0;
            if (j == 0) bus.cnt_max = 16'd20;
        end

        // Asynchronous reset mid-cycle at count 5.
        tick();
        #1 rst = 1'b1;
        push(500, ALL, 0, 0, 0, 0, 0, 0);
        tick();
        push(501, ALL, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        push(502, ALL, 0, 1, 1, 0, 0, 0);
        tick();
        push(503, ALL, 1, 1, 1, 1, 0, 0);

        // Stop for one cycle, clear the interrupt, switch to network lock, P=100.
        bus.enable    = 1'b0;
        bus.irq_ack   = 1'b1;
        bus.cnt_max   = 16'd100;
        bus.sync_mode = 1'b1;
        bus.ch_enable = 4'h0;
        tick();
        push(600, ALL, 0, 0, 0, 0, 0, 0);
        bus.enable  = 1'b1;
        bus.irq_ack = 1'b0;

        // Resync at count 40, then holdover for two wraps, then a fresh edge.
        for (int n = 0; n <= 262; n++) begin
            int lost;
            tick();
            if (n <= 42)       c = n;
            else if (n <= 257) c = (n - 43) % 100;
            else               c = n - 258;
            lost = (n >= 243 && n <= 257) ? 1 : 0;
            if (n <= 45)
                push(1000 + n, ALL, c, int'(c < 3), 0,
                     int'((n >= 1 && n <= 10) || n >= 44), 0, lost);
            else
                push(1000 + n, NO_IRQ, c, int'(c < 3), 0, 0, 0, lost);
            bus.network_sync = (n >= 40 && n < 250) || (n >= 255);
            bus.irq_ack      = (n == 10);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_sync_gen.md
MULTI_SYNC_GEN -- requirements
Module: multi_sync_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of phase-offset channel sync outputs.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the period counter and of the period and offset values.
REQ-003 The block SHALL have parameter PW_W, default 8, meaning the width of the pulse-width value.
REQ-004 clock_sync  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  run control; 0 = stopped.
REQ-007 sync_mode  in  1  0 = free-run; 1 = network-lock.
REQ-008 cnt_max  in  CNT_W  period in clocks.
REQ-009 pulse_width  in  PW_W  sync pulse width in clocks.
REQ-010 phase_offset  in  NUM_CH*CNT_W  per-channel offset; channel i uses bits [i*CNT_W +: CNT_W].
REQ-011 ch_enable  in  NUM_CH  per-channel output gate.
REQ-012 network_sync  in  1  asynchronous external sync.
REQ-013 irq_ack  in  1  single-cycle interrupt clear.
REQ-014 period_count  out  CNT_W  current counter value.
REQ-015 master_sync  out  1  period-start pulse.
REQ-016 ch_sync  out  NUM_CH  per-channel pulses.
REQ-017 interrupt_sig  out  1  sticky period-start interrupt.
REQ-018 irq_overrun  out  1  sticky missed-ack flag.
REQ-019 sync_lost  out  1  network-lock loss flag.

Function
REQ-020 Shadow copies of cnt_max, pulse_width and phase_offset SHALL load every cycle while stopped and on every period start while running; all timing uses shadows only.
REQ-021 Effective period P = max(shadow cnt_max, 2); effective width W = clamp(shadow pulse_width, 1, P-1).
REQ-022 network_sync SHALL pass through a 2-flop synchroniser; net_edge = synchronised rising edge; net_edge is ignored when sync_mode=0 or the block is stopped.
REQ-023 Stopped (enable=0): period_count held 0; master_sync and ch_sync 0; sticky flags hold.
REQ-024 The first edge sampling enable=1 while stopped SHALL start the block: period_count=0, this cycle is a period start.
REQ-025 Running: period_count SHALL increment by 1 per clock and wrap from P-1 to 0; each cycle at 0 is a period start.
REQ-026 net_edge SHALL force period_count to 0 on the next edge (period start) regardless of current value; simultaneous natural wrap yields a single period start.
REQ-027 Network latency: period_count = 0 on the 3rd rising edge after network_sync is first sampled high.
REQ-028 master_sync SHALL be 1 exactly in cycles where running and period_count < W; registered, glitch-free.
REQ-029 ch_sync[i] SHALL be 1 exactly in cycles where running, ch_enable[i]=1, offset_i < P, and (period_count - offset_i) mod P < W; window wraps across the period boundary.
REQ-030 offset_i >= P SHALL hold ch_sync[i] at 0.
REQ-031 A resync truncating a period SHALL not extend any pulse; outputs follow the new period_count immediately.
REQ-032 interrupt_sig SHALL set on every period start and clear on irq_ack; set wins over simultaneous ack.
REQ-033 irq_overrun SHALL set when a period start occurs while interrupt_sig is already 1; cleared by irq_ack unless set in the same cycle.
REQ-034 In sync_mode=1, sync_lost SHALL set on the second consecutive natural wrap without an intervening net_edge; cleared by the next net_edge; counting continues free-running (holdover).
REQ-035 sync_lost SHALL be 0 whenever sync_mode=0 or the block is stopped.
REQ-036 A net_edge that both restarts the count and clears sync_lost SHALL also reset the missed-wrap tally to 0.

Reset
REQ-037 reset=1 SHALL immediately clear period_count, master_sync, ch_sync, interrupt_sig, irq_overrun, sync_lost, the synchroniser, the run state, the tally, and all shadows.
REQ-038 Reset mid-period SHALL abandon the period; after release the block restarts per REQ-024 only.

Verification
REQ-039 cnt_max=10, pulse_width=3, mode 0, enable rises -> period_count 0..9 repeating; master_sync high on counts 0-2; interrupt_sig set at each count 0.
REQ-040 Offsets {0,4,8,9}, P=10, W=3 -> ch_sync[3] high on counts 9,0,1; ch_sync[2] high on 8,9,0; offset 12 on any channel -> that channel held 0.
REQ-041 Mode 1, P=100, network_sync rises at count 40 -> count 0 three edges later; single interrupt; no sync_lost.
REQ-042 Mode 1, no network edges for 2 periods -> sync_lost=1 at the 2nd wrap; next edge clears it.
REQ-043 No irq_ack across two period starts -> irq_overrun=1; ack coinciding with a period start -> interrupt_sig stays 1.
REQ-044 Change cnt_max 10->20 mid-period; assert reset at count 5 -> new period applies only after wrap; all outputs 0 asynchronously on reset.
